// File: rtl/vector_exec_unit.sv
// Multi-cycle vector execution unit: NREG vector registers of VLEN elements,
// LANES elements processed per beat, plus a chunk memory for LOAD/STORE.
// Ports:
//   clk, reset                  clock, async active-high reset
//   instr_valid/instr           instruction handshake {op, vd, va, vb, addr}
//   instr_ready, busy           IDLE / EXEC indication
//   done, err                   completion / illegal-opcode pulses
//   sat_flag                    sticky ADDS saturation flag
//   mem_wr_en/addr/data         memory preload port (ignored while busy)
//   rd_sel, rd_data             combinational register readback
module vector_exec_unit #(
  parameter int unsigned ELEM_W = 32,
  parameter int unsigned VLEN   = 16,
  parameter int unsigned LANES  = 4,
  parameter int unsigned NREG   = 4,
  parameter int unsigned ADDR_W = 9,
  localparam int unsigned RW      = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int unsigned INSTR_W = 4 + 3 * RW + ADDR_W,
  localparam int unsigned CW      = LANES * ELEM_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  input  logic [INSTR_W-1:0]       instr,
  output logic                     instr_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     sat_flag,
  input  logic                     mem_wr_en,
  input  logic [ADDR_W-1:0]        mem_wr_addr,
  input  logic [CW-1:0]            mem_wr_data,
  input  logic [RW-1:0]            rd_sel,
  output logic [VLEN*ELEM_W-1:0]   rd_data
);

  localparam int unsigned NB    = VLEN / LANES;
  localparam int unsigned BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_MUL   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_ADDS  = 4'b0011;
  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;
  localparam logic [3:0] OP_CLRF  = 4'b1110;
  localparam logic [3:0] OP_NOP   = 4'b1111;

  localparam logic [ELEM_W-1:0] SMAX = {1'b0, {(ELEM_W-1){1'b1}}};
  localparam logic [ELEM_W-1:0] SMIN = {1'b1, {(ELEM_W-1){1'b0}}};

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t               state, state_next;
  logic [INSTR_W-1:0]   cur, cur_next;
  logic [BW-1:0]        beat, beat_next;
  logic                 done_next, err_next, sat_next;
  logic                 vreg_we, mem_we;

  logic [VLEN*ELEM_W-1:0] vreg [NREG];
  logic [CW-1:0]          mem  [DEPTH];

  logic [3:0]           op, in_op;
  logic [RW-1:0]        vd, va, vb;
  logic [ADDR_W-1:0]    addr, mem_addr;
  logic [CW-1:0]        a_chunk, b_chunk, alu_res, mem_rd;
  logic [LANES-1:0]     lane_sat;

  // Latched instruction fields
  assign addr  = cur[ADDR_W-1:0];
  assign vb    = cur[ADDR_W +: RW];
  assign va    = cur[ADDR_W+RW +: RW];
  assign vd    = cur[ADDR_W+2*RW +: RW];
  assign op    = cur[ADDR_W+3*RW +: 4];
  assign in_op = instr[INSTR_W-1 -: 4];

  assign rd_data  = vreg[rd_sel];
  assign mem_addr = addr + ADDR_W'(beat);
  assign mem_rd   = mem[mem_addr];

  // One lane: {saturated, result}
  function automatic logic [ELEM_W:0] lane_op(input logic [3:0] o,
                                              input logic [ELEM_W-1:0] a,
                                              input logic [ELEM_W-1:0] b);
    logic [ELEM_W-1:0] sum;
    logic              ovf;
    sum     = a + b;
    ovf     = (a[ELEM_W-1] == b[ELEM_W-1]) && (sum[ELEM_W-1] != a[ELEM_W-1]);
    lane_op = {1'b0, sum};
    case (o)
      OP_MUL:  lane_op = {1'b0, ELEM_W'(a * b)};
      OP_SUB:  lane_op = {1'b0, ELEM_W'(a - b)};
      OP_ADDS: if (ovf) lane_op = {1'b1, a[ELEM_W-1] ? SMIN : SMAX};
      default: lane_op = {1'b0, sum};
    endcase
  endfunction

  // Per-beat datapath over the current chunk
  always_comb begin
    logic [ELEM_W:0] r;
    a_chunk  = vreg[va][beat*CW +: CW];
    b_chunk  = vreg[vb][beat*CW +: CW];
    alu_res  = '0;
    lane_sat = '0;
    r        = '0;
    for (int j = 0; j < LANES; j++) begin
      r = lane_op(op, a_chunk[j*ELEM_W +: ELEM_W], b_chunk[j*ELEM_W +: ELEM_W]);
      alu_res[j*ELEM_W +: ELEM_W] = r[ELEM_W-1:0];
      lane_sat[j] = r[ELEM_W];
    end
  end

  // Next-state and control
  always_comb begin
    state_next = state;
    cur_next   = cur;
    beat_next  = beat;
    done_next  = 1'b0;
    err_next   = 1'b0;
    sat_next   = sat_flag;
    vreg_we    = 1'b0;
    mem_we     = 1'b0;
    case (state)
      S_IDLE: begin
        if (instr_valid) begin
          case (in_op)
            OP_NOP:  done_next = 1'b1;
            OP_CLRF: begin
              done_next = 1'b1;
              sat_next  = 1'b0;
            end
            OP_ADD, OP_MUL, OP_SUB, OP_ADDS, OP_LOAD, OP_STORE: begin
              state_next = S_EXEC;
              cur_next   = instr;
              beat_next  = '0;
            end
            default: err_next = 1'b1;
          endcase
        end
      end
      S_EXEC: begin
        if (op == OP_STORE) mem_we = 1'b1;
        else                vreg_we = 1'b1;
        if (op == OP_ADDS && |lane_sat) sat_next = 1'b1;
        if (beat == BW'(NB - 1)) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          beat_next = beat + BW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cur         <= '0;
      beat        <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      sat_flag    <= 1'b0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      cur         <= cur_next;
      beat        <= beat_next;
      done        <= done_next;
      err         <= err_next;
      sat_flag    <= sat_next;
      instr_ready <= (state_next == S_IDLE);
      busy        <= (state_next == S_EXEC);
    end
  end

  // Register file: one chunk of vd per beat; operands were read from the same chunk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) vreg[r] <= '0;
    end else if (vreg_we) begin
      vreg[vd][beat*CW +: CW] <= (op == OP_LOAD) ? mem_rd : alu_res;
    end
  end

  // Chunk memory, not reset; preload is blocked while executing
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_addr] <= a_chunk;
    else if (mem_wr_en && state != S_EXEC)
      mem[mem_wr_addr] <= mem_wr_data;
  end

endmodule

// File: tb/tb_vector_exec_unit.sv
// Directed self-checking bench for vector_exec_unit (default parameters).
module tb_vector_exec_unit;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_MUL   = 4'b0001;
  localparam logic [3:0] OP_ADDS  = 4'b0011;
  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;
  localparam logic [3:0] OP_ILL   = 4'b0101;
  localparam logic [3:0] OP_CLRF  = 4'b1110;

  logic         clk;
  logic         reset;
  logic         instr_valid;
  logic [18:0]  instr;
  logic         instr_ready;
  logic         busy;
  logic         done;
  logic         err;
  logic         sat_flag;
  logic         mem_wr_en;
  logic [8:0]   mem_wr_addr;
  logic [127:0] mem_wr_data;
  logic [1:0]   rd_sel;
  logic [511:0] rd_data;

  int           n_cmp;
  int           n_mis;
  int           lat;
  int           busy_cnt;
  logic         saw_done;
  logic         saw_err;
  logic         rdy_end;
  logic [511:0] exp_v [4];
  logic [127:0] ch;

  vector_exec_unit dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .sat_flag    (sat_flag),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reg(input int r, input string tag);
    rd_sel = 2'(r);
    #1;
    chk(tag, rd_data, exp_v[r]);
  endtask

  task automatic preload(input logic [8:0] a, input logic [127:0] d);
    @(negedge clk);
    mem_wr_en = 1'b1; mem_wr_addr = a; mem_wr_data = d;
    @(posedge clk); #1;
    mem_wr_en = 1'b0;
  endtask

  // Issue one instruction (optionally with a same-cycle preload) and wait, bounded, for done/err
  task automatic issue(input logic [3:0] op, input logic [1:0] vd, input logic [1:0] va,
                       input logic [1:0] vb, input logic [8:0] a,
                       input logic pe, input logic [8:0] pa, input logic [127:0] pd);
    @(negedge clk);
    instr = {op, vd, va, vb, a};
    instr_valid = 1'b1;
    mem_wr_en = pe; mem_wr_addr = pa; mem_wr_data = pd;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    mem_wr_en = 1'b0;
    lat = 0; busy_cnt = 0; saw_done = 1'b0; saw_err = 1'b0; rdy_end = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || err) begin
        saw_done = done; saw_err = err; rdy_end = instr_ready;
        break;
      end
      if (!instr_ready) lat++;
      if (busy) busy_cnt++;
    end
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    reset = 1'b1; instr_valid = 1'b0; instr = '0;
    mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0; rd_sel = '0;
    for (int r = 0; r < 4; r++) exp_v[r] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 512'(instr_ready), 512'(1));
    chk("rst_busy",  512'(busy), 512'(0));
    chk("rst_done",  512'(done), 512'(0));
    chk("rst_err",   512'(err), 512'(0));
    chk("rst_sat",   512'(sat_flag), 512'(0));
    chk_reg(0, "rst_v0");
    chk_reg(3, "rst_v3");
    @(negedge clk);
    reset = 1'b0;

    // mem[0..3] = elements 1..16
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) ch[j*32 +: 32] = 32'(k*4 + j + 1);
      preload(9'(k), ch);
    end

    // LOAD v0 <- mem[0]
    issue(OP_LOAD, 2'd0, 2'd0, 2'd0, 9'd0, 1'b0, 9'd0, '0);
    for (int i = 0; i < 16; i++) exp_v[0][i*32 +: 32] = 32'(i + 1);
    chk("load0_done", 512'(saw_done), 512'(1));
    chk("load0_lat", 512'(lat), 512'(4));
    chk("load0_busy", 512'(busy_cnt), 512'(4));
    chk("load0_rdy", 512'(rdy_end), 512'(1));
    chk_reg(0, "load0_v0");
    @(negedge clk);
    chk("load0_pulse", 512'(done), 512'(0));

    // LOAD v1 <- all 2s
    for (int k = 4; k < 8; k++) preload(9'(k), {4{32'h2}});
    issue(OP_LOAD, 2'd1, 2'd0, 2'd0, 9'd4, 1'b0, 9'd0, '0);
    for (int i = 0; i < 16; i++) exp_v[1][i*32 +: 32] = 32'h2;
    chk_reg(1, "load1_v1");

    // ADD v2 = v0 + v1
    issue(OP_ADD, 2'd2, 2'd0, 2'd1, 9'd0, 1'b0, 9'd0, '0);
    for (int i = 0; i < 16; i++) exp_v[2][i*32 +: 32] = 32'(i + 3);
    chk("add_lat", 512'(lat), 512'(4));
    chk_reg(2, "add_v2");

    // MUL v3 = v0 * v1
    issue(OP_MUL, 2'd3, 2'd0, 2'd1, 9'd0, 1'b0, 9'd0, '0);
    for (int i = 0; i < 16; i++) exp_v[3][i*32 +: 32] = 32'(2 * (i + 1));
    chk("mul_lat", 512'(lat), 512'(4));
    chk_reg(3, "mul_v3");

    // ADDS positive saturation, fully aliased v3 = v3 + v3
    for (int k = 8; k < 12; k++) preload(9'(k), {4{32'h7FFF_FFFF}});
    issue(OP_LOAD, 2'd3, 2'd0, 2'd0, 9'd8, 1'b0, 9'd0, '0);
    for (int i = 0; i < 16; i++) exp_v[3][i*32 +: 32] = 32'h7FFF_FFFF;
    chk("pre_adds_sat", 512'(sat_flag), 512'(0));
    issue(OP_ADDS, 2'd3, 2'd3, 2'd3, 9'd0, 1'b0, 9'd0, '0);
    chk_reg(3, "adds_pos_v3");
    chk("adds_pos_sat", 512'(sat_flag), 512'(1));

    // Plain ADD leaves the sticky flag
    issue(OP_ADD, 2'd3, 2'd0, 2'd1, 9'd0, 1'b0, 9'd0, '0);
    for (int i = 0; i < 16; i++) exp_v[3][i*32 +: 32] = 32'(i + 3);
    chk_reg(3, "add_after_sat_v3");
    chk("sticky_sat", 512'(sat_flag), 512'(1));

    // CLRF
    issue(OP_CLRF, 2'd0, 2'd0, 2'd0, 9'd0, 1'b0, 9'd0, '0);
    chk("clrf_done", 512'(saw_done), 512'(1));
    chk("clrf_lat", 512'(lat), 512'(0));
    chk("clrf_sat", 512'(sat_flag), 512'(0));

    // Non-saturating ADDS
    issue(OP_ADDS, 2'd2, 2'd0, 2'd1, 9'd0, 1'b0, 9'd0, '0);
    chk_reg(2, "adds_nosat_v2");
    chk("adds_nosat_sat", 512'(sat_flag), 512'(0));

    // ADDS negative saturation
    for (int k = 12; k < 16; k++) preload(9'(k), {4{32'h8000_0000}});
    issue(OP_LOAD, 2'd3, 2'd0, 2'd0, 9'd12, 1'b0, 9'd0, '0);
    issue(OP_ADDS, 2'd3, 2'd3, 2'd3, 9'd0, 1'b0, 9'd0, '0);
    for (int i = 0; i < 16; i++) exp_v[3][i*32 +: 32] = 32'h8000_0000;
    chk_reg(3, "adds_neg_v3");
    chk("adds_neg_sat", 512'(sat_flag), 512'(1));

    // STORE v2 at 0x1FE with address wrap, then read back
    issue(OP_STORE, 2'd0, 2'd2, 2'd0, 9'h1FE, 1'b0, 9'd0, '0);
    chk("store_done", 512'(saw_done), 512'(1));
    chk("store_lat", 512'(lat), 512'(4));
    issue(OP_LOAD, 2'd3, 2'd0, 2'd0, 9'h1FE, 1'b0, 9'd0, '0);
    exp_v[3] = exp_v[2];
    chk_reg(3, "store_load_v3");
    issue(OP_LOAD, 2'd1, 2'd0, 2'd0, 9'h000, 1'b0, 9'd0, '0);
    for (int i = 0; i < 8; i++)  exp_v[1][i*32 +: 32] = 32'(i + 11);
    for (int i = 8; i < 16; i++) exp_v[1][i*32 +: 32] = 32'(i + 1);
    chk_reg(1, "store_wrap_v1");

    // Illegal opcode
    issue(OP_ILL, 2'd0, 2'd1, 2'd2, 9'd0, 1'b0, 9'd0, '0);
    chk("ill_err", 512'(saw_err), 512'(1));
    chk("ill_done", 512'(saw_done), 512'(0));
    chk("ill_lat", 512'(lat), 512'(0));
    chk("ill_ready", 512'(rdy_end), 512'(1));
    @(negedge clk);
    chk("ill_pulse", 512'(err), 512'(0));
    for (int r = 0; r < 4; r++) chk_reg(r, "ill_vreg");
    chk("ill_sat", 512'(sat_flag), 512'(1));

    // Preload coinciding with accept is visible to beat 0
    for (int k = 1; k < 4; k++) begin
      for (int j = 0; j < 4; j++) ch[j*32 +: 32] = 32'(32'h100 + k*4 + j);
      preload(9'(9'h20 + k), ch);
    end
    for (int j = 0; j < 4; j++) ch[j*32 +: 32] = 32'(32'h100 + j);
    issue(OP_LOAD, 2'd2, 2'd0, 2'd0, 9'h20, 1'b1, 9'h20, ch);
    for (int i = 0; i < 16; i++) exp_v[2][i*32 +: 32] = 32'(32'h100 + i);
    chk_reg(2, "pre_accept_v2");

    // Reset during beat 2 of STORE v0 -> addr 8
    @(negedge clk);
    instr = {OP_STORE, 2'd0, 2'd0, 2'd0, 9'd8};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 512'(busy), 512'(1));
    reset = 1'b1;
    #1;
    for (int r = 0; r < 4; r++) exp_v[r] = '0;
    chk("mid_rst_ready", 512'(instr_ready), 512'(1));
    chk("mid_rst_busy", 512'(busy), 512'(0));
    chk("mid_rst_done", 512'(done), 512'(0));
    chk("mid_rst_err", 512'(err), 512'(0));
    chk("mid_rst_sat", 512'(sat_flag), 512'(0));
    chk_reg(0, "mid_rst_v0");
    @(negedge clk);
    reset = 1'b0;

    // mem[8..9] hold stored chunks, mem[10..11] untouched
    issue(OP_LOAD, 2'd1, 2'd0, 2'd0, 9'd8, 1'b0, 9'd0, '0);
    for (int i = 0; i < 8; i++)  exp_v[1][i*32 +: 32] = 32'(i + 1);
    for (int i = 8; i < 16; i++) exp_v[1][i*32 +: 32] = 32'h7FFF_FFFF;
    chk("post_rst_done", 512'(saw_done), 512'(1));
    chk("post_rst_lat", 512'(lat), 512'(4));
    chk_reg(1, "post_rst_v1");
    chk_reg(0, "post_rst_v0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
